// File: rtl/i2c_init_sequencer.sv
// I2C init sequencer: walks a command table and issues one I2C write per entry.
// Define I2C_INIT_RETRY_EN to retry NACKed entries up to RETRY_MAX extra times.
module i2c_init_sequencer #(
   parameter logic [6:0]  I2C_DEV_ADDR = 7'h39,
   parameter logic [7:0]  NUM_CMDS     = 8'd32,
   parameter logic [15:0] START_DELAY  = 16'd1000,
   parameter int unsigned RETRY_MAX    = 3,
   parameter logic [7:0]  END_TIMEOUT  = 8'd64
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        GO,
   output logic [7:0]  TBL_ADDR,
   input  logic [15:0] TBL_DATA,
   output logic        I2C_START,
   output logic        I2C_READ,
   output logic [6:0]  I2C_ADDR,
   output logic [7:0]  I2C_SUBADDR,
   output logic [7:0]  I2C_WDATA,
   input  logic        I2C_END,
   input  logic        I2C_ACK,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERROR,
   output logic [7:0]  ERR_INDEX
);

   typedef enum logic [3:0] {
      S_IDLE, S_DELAY, S_FETCH, S_LATCH, S_ISSUE,
      S_WAIT_END, S_CHECK, S_NEXT, S_DONE, S_FAIL
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  index_q, index_d;
   logic [15:0] dly_q, dly_d;
   logic [7:0]  to_q, to_d;
   logic [7:0]  sub_q, sub_d;
   logic [7:0]  wdat_q, wdat_d;
   logic [7:0]  err_q, err_d;
   logic        start_q, start_d;
   logic        go_q;
   logic        go_rise;
`ifdef I2C_INIT_RETRY_EN
   logic [7:0]  retry_q, retry_d;
`endif

   assign go_rise = GO & ~go_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         index_q <= '0;
         dly_q   <= '0;
         to_q    <= '0;
         sub_q   <= '0;
         wdat_q  <= '0;
         err_q   <= '0;
         start_q <= 1'b0;
         go_q    <= 1'b0;
`ifdef I2C_INIT_RETRY_EN
         retry_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         dly_q   <= dly_d;
         to_q    <= to_d;
         sub_q   <= sub_d;
         wdat_q  <= wdat_d;
         err_q   <= err_d;
         start_q <= start_d;
         go_q    <= GO;
`ifdef I2C_INIT_RETRY_EN
         retry_q <= retry_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      dly_d   = dly_q;
      to_d    = to_q;
      sub_d   = sub_q;
      wdat_d  = wdat_q;
      err_d   = err_q;
      start_d = start_q;
`ifdef I2C_INIT_RETRY_EN
      retry_d = retry_q;
`endif
      case (state_q)
         S_IDLE: begin
            dly_d   = '0;
            state_d = S_DELAY;
         end
         S_DELAY: begin
            if (({1'b0, dly_q} + 17'd1) >= {1'b0, START_DELAY}) begin
               index_d = '0;
               state_d = S_FETCH;
            end else begin
               dly_d = dly_q + 16'd1;
            end
         end
         S_FETCH: state_d = S_LATCH;
         S_LATCH: begin
            sub_d   = TBL_DATA[15:8];
            wdat_d  = TBL_DATA[7:0];
            to_d    = '0;
            state_d = S_ISSUE;
         end
         // START only rises against an idle master; the timeout counts cycles
         // with START high while the master still reports idle.
         S_ISSUE: begin
            if (!start_q) begin
               if (I2C_END) start_d = 1'b1;
            end else if (!I2C_END) begin
               start_d = 1'b0;
               state_d = S_WAIT_END;
            end else if (to_q == (END_TIMEOUT - 8'd1)) begin
               start_d = 1'b0;
               err_d   = index_q;
               state_d = S_FAIL;
            end else begin
               to_d = to_q + 8'd1;
            end
         end
         S_WAIT_END: begin
            if (I2C_END) state_d = S_CHECK;
         end
         S_CHECK: begin
            if (I2C_ACK) begin
               state_d = S_NEXT;
            end
`ifdef I2C_INIT_RETRY_EN
            else if (32'(retry_q) < RETRY_MAX) begin
               retry_d = retry_q + 8'd1;
               to_d    = '0;
               state_d = S_ISSUE;
            end
`endif
            else begin
               err_d   = index_q;
               state_d = S_FAIL;
            end
         end
         S_NEXT: begin
`ifdef I2C_INIT_RETRY_EN
            retry_d = '0;
`endif
            if (index_q == (NUM_CMDS - 8'd1)) begin
               state_d = S_DONE;
            end else begin
               index_d = index_q + 8'd1;
               state_d = S_FETCH;
            end
         end
         S_DONE, S_FAIL: begin
            if (go_rise) begin
               index_d = '0;
               err_d   = '0;
`ifdef I2C_INIT_RETRY_EN
               retry_d = '0;
`endif
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign TBL_ADDR    = index_q;
   assign I2C_START   = start_q;
   assign I2C_READ    = 1'b0;
   assign I2C_ADDR    = I2C_DEV_ADDR;
   assign I2C_SUBADDR = sub_q;
   assign I2C_WDATA   = wdat_q;
   assign ERR_INDEX   = err_q;
   assign BUSY        = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);
   assign DONE        = (state_q == S_DONE);
   assign ERROR       = (state_q == S_FAIL);

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Bench for i2c_init_sequencer: table ROM, I2C master model and transfer scoreboard.
module tb_i2c_init_sequencer;

   localparam int NV = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        go = 1'b0;
   logic [7:0]  tbl_addr;
   logic [15:0] tbl_data = '0;
   logic        i2c_start, i2c_read;
   logic [6:0]  i2c_addr;
   logic [7:0]  i2c_subaddr, i2c_wdata;
   logic        i2c_end = 1'b1;
   logic        i2c_ack = 1'b1;
   logic        busy, done, error;
   logic [7:0]  err_index;

   i2c_init_sequencer #(
      .I2C_DEV_ADDR(7'h39),
      .NUM_CMDS    (8'd3),
      .START_DELAY (16'd100),
      .RETRY_MAX   (3),
      .END_TIMEOUT (8'd64)
   ) dut (
      .CLK        (clk),
      .RESET_N    (rst_n),
      .GO         (go),
      .TBL_ADDR   (tbl_addr),
      .TBL_DATA   (tbl_data),
      .I2C_START  (i2c_start),
      .I2C_READ   (i2c_read),
      .I2C_ADDR   (i2c_addr),
      .I2C_SUBADDR(i2c_subaddr),
      .I2C_WDATA  (i2c_wdata),
      .I2C_END    (i2c_end),
      .I2C_ACK    (i2c_ack),
      .BUSY       (busy),
      .DONE       (done),
      .ERROR      (error),
      .ERR_INDEX  (err_index)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Command table ROM with one cycle read latency.
   logic [15:0] rom [3];
   always @(posedge clk)
      tbl_data <= (tbl_addr < 8'd3) ? rom[tbl_addr[1:0]] : 16'hDEAD;

   // Master model and scoreboard: each accepted START pops one expected {subaddr,data}.
   logic [15:0] sb_q[$];
   int   n_rises = 0;
   bit   hang = 0;
   int   nack_left = 0;
   logic [7:0] nack_sub = '0;
   bit   m_busy = 0;
   int   m_cnt = 0;
   bit   ack_this = 1;
   logic start_prev = 1'b0;

   always @(negedge clk) begin
      logic [15:0] exp_x;
      if (i2c_start === 1'b1 && start_prev !== 1'b1) n_rises++;
      if (!m_busy) begin
         if (i2c_start === 1'b1 && start_prev !== 1'b1 && !hang && i2c_end) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_xfer", {i2c_subaddr, i2c_wdata}, 16'hFFFF);
            end else begin
               exp_x = sb_q.pop_front();
               check("sb_subaddr", i2c_subaddr, exp_x[15:8]);
               check("sb_wdata", i2c_wdata, exp_x[7:0]);
            end
            check("xfer_dev_addr", i2c_addr, 7'h39);
            check("xfer_read", i2c_read, 1'b0);
            ack_this = !(i2c_subaddr == nack_sub && nack_left > 0);
            if (!ack_this) nack_left--;
            i2c_end = 1'b0;
            i2c_ack = 1'b0;
            m_cnt   = 3;
            m_busy  = 1;
         end
      end else if (m_cnt == 0) begin
         i2c_end = 1'b1;
         i2c_ack = ack_this;
         m_busy  = 0;
      end else begin
         m_cnt--;
      end
      start_prev = i2c_start;
   end

   task automatic pulse_go();
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_finish(input string name, input int budget);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done === 1'b1 || error === 1'b1) begin
            ok = 1;
            break;
         end
      end
      check(name, ok, 1'b1);
   endtask

   // Releases reset and counts cycles to the first START rise.
   task automatic release_and_time(input string name);
      int  cnt = 0;
      bit  seen = 0;
      rst_n = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         cnt++;
         if (i2c_start === 1'b1) begin
            seen = 1;
            break;
         end
      end
      check({name, "_seen"}, seen, 1'b1);
      check({name, "_ge100"}, (cnt >= 100), 1'b1);
   endtask

   task automatic push_entries(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                               input int att1, input bit inc2);
      sb_q.push_back(e0);
      for (int a = 0; a < att1; a++) sb_q.push_back(e1);
      if (inc2) sb_q.push_back(e2);
   endtask

   typedef struct {
      logic [15:0] e0, e1, e2;
      int          nacks;
      bit          go_mid;
      bit          exp_done;
      logic [7:0]  exp_err_idx;
      int          exp_e1_att;
   } vec_t;

   vec_t vec [NV];

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int r0;
      bit ok;
`ifdef I2C_INIT_RETRY_EN
      vec[0] = '{16'h1101, 16'h2202, 16'h3303, 0, 1'b1, 1'b1, 8'd0, 1};
      vec[1] = '{16'h10AA, 16'h20BB, 16'h30CC, 1, 1'b0, 1'b1, 8'd0, 2};
      vec[2] = '{16'h4455, 16'h5566, 16'h6677, 2, 1'b0, 1'b1, 8'd0, 3};
      vec[3] = '{16'h0F0E, 16'hA1B2, 16'hC3D4, 4, 1'b0, 1'b0, 8'd1, 4};
`else
      vec[0] = '{16'h1101, 16'h2202, 16'h3303, 0, 1'b1, 1'b1, 8'd0, 1};
      vec[1] = '{16'h10AA, 16'h20BB, 16'h30CC, 1, 1'b0, 1'b0, 8'd1, 1};
      vec[2] = '{16'h4455, 16'h5566, 16'h6677, 2, 1'b0, 1'b0, 8'd1, 1};
      vec[3] = '{16'h0F0E, 16'hA1B2, 16'hC3D4, 4, 1'b0, 1'b0, 8'd1, 1};
`endif

      // Reset values
      rom[0] = 16'h10AA; rom[1] = 16'h20BB; rom[2] = 16'h30CC;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_start", i2c_start, 1'b0);
      check("rst_tbl_addr", tbl_addr, 8'd0);
      check("rst_subaddr", i2c_subaddr, 8'd0);
      check("rst_wdata", i2c_wdata, 8'd0);
      check("rst_err_index", err_index, 8'd0);
      check("rst_read", i2c_read, 1'b0);
      check("rst_dev_addr", i2c_addr, 7'h39);

      // Power-up sequence: full start delay then three acked writes
      push_entries(16'h10AA, 16'h20BB, 16'h30CC, 1, 1'b1);
      r0 = n_rises;
      release_and_time("first_start");
      check("first_busy", busy, 1'b1);
      wait_finish("first_finish", 2000);
      check("first_done", done, 1'b1);
      check("first_busy_end", busy, 1'b0);
      check("first_error", error, 1'b0);
      check("first_rises", n_rises - r0, 3);
      check("first_sb_empty", sb_q.size(), 0);
      check("first_idx_held", tbl_addr, 8'd2);

      // Table-driven restarts with NACK patterns
      for (int v = 0; v < NV; v++) begin
         rom[0] = vec[v].e0; rom[1] = vec[v].e1; rom[2] = vec[v].e2;
         push_entries(vec[v].e0, vec[v].e1, vec[v].e2, vec[v].exp_e1_att, vec[v].exp_done);
         nack_sub  = vec[v].e1[15:8];
         nack_left = vec[v].nacks;
         r0 = n_rises;
         pulse_go();
         if (vec[v].go_mid) begin
            ok = 0;
            for (int i = 0; i < 200; i++) begin
               @(negedge clk);
               if (n_rises > r0) begin ok = 1; break; end
            end
            check("vec_go_mid_wait", ok, 1'b1);
            pulse_go();
         end
         wait_finish($sformatf("vec%0d_finish", v), 3000);
         check($sformatf("vec%0d_done", v), done, vec[v].exp_done);
         check($sformatf("vec%0d_error", v), error, !vec[v].exp_done);
         check($sformatf("vec%0d_err_index", v), err_index, vec[v].exp_err_idx);
         check($sformatf("vec%0d_busy", v), busy, 1'b0);
         repeat (50) @(negedge clk);
         check($sformatf("vec%0d_rises", v), n_rises - r0,
               1 + vec[v].exp_e1_att + (vec[v].exp_done ? 1 : 0));
         check($sformatf("vec%0d_sb_empty", v), sb_q.size(), 0);
      end

      // END stuck high: timeout on entry 0, then GO recovers
      rom[0] = 16'h10AA; rom[1] = 16'h20BB; rom[2] = 16'h30CC;
      nack_left = 0;
      hang = 1;
      pulse_go();
      begin
         int  cnt = 0;
         bit  seen = 0;
         for (int i = 0; i < 50; i++) begin
            if (i2c_start === 1'b1) begin seen = 1; break; end
            @(negedge clk);
         end
         check("to_start_seen", seen, 1'b1);
         for (int i = 0; i < 200; i++) begin
            if (error === 1'b1) break;
            @(negedge clk);
            cnt++;
         end
         check("to_cycles", cnt, 64);
      end
      check("to_error", error, 1'b1);
      check("to_err_index", err_index, 8'd0);
      check("to_start_low", i2c_start, 1'b0);
      hang = 0;
      push_entries(16'h10AA, 16'h20BB, 16'h30CC, 1, 1'b1);
      pulse_go();
      repeat (2) @(negedge clk);
      check("to_restart_error_clr", error, 1'b0);
      check("to_restart_err_index", err_index, 8'd0);
      check("to_restart_busy", busy, 1'b1);
      wait_finish("to_restart_finish", 2000);
      check("to_restart_done", done, 1'b1);
      check("to_restart_sb_empty", sb_q.size(), 0);

      // Reset while entry 2 is in WAIT_END
      push_entries(16'h10AA, 16'h20BB, 16'h30CC, 1, 1'b1);
      r0 = n_rises;
      pulse_go();
      ok = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (n_rises - r0 == 3 && i2c_start === 1'b0 && i2c_end === 1'b0) begin ok = 1; break; end
      end
      check("mid_reach_wait_end", ok, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_start", i2c_start, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_tbl_addr", tbl_addr, 8'd0);
      repeat (2) @(negedge clk);
      push_entries(16'h10AA, 16'h20BB, 16'h30CC, 1, 1'b1);
      r0 = n_rises;
      release_and_time("mid_restart");
      wait_finish("mid_finish", 2000);
      check("mid_done", done, 1'b1);
      check("mid_rises", n_rises - r0, 3);
      check("mid_sb_empty", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
